// File: rtl/grf_wport_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority over the MDU result path,
// with a starvation counter that requests a pipeline bubble and a busy scoreboard for MDU results.
module grf_wport_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic [31:0] wb_pc,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_addr,
    input  logic [31:0] mdu_data,
    input  logic [31:0] mdu_pc,
    input  logic        issue_valid,
    input  logic [4:0]  issue_addr,
    output logic        stall_req,
    output logic [31:0] busy,
    output logic        grf_we,
    output logic [4:0]  grf_a3,
    output logic [31:0] grf_wd,
    output logic [31:0] grf_pc
);

    localparam logic [CNT_W-1:0] WAIT_TC = CNT_W'(MAX_WAIT);

    logic             wb_eff;
    logic [CNT_W-1:0] wait_cnt;
    logic [31:0]      busy_nxt;

    // A pipeline write to $0 is a no-op and must not steal the slot from the MDU.
    assign wb_eff    = wb_valid && (wb_addr != 5'd0);
    assign mdu_ready = mdu_valid && !wb_eff;
    assign stall_req = (wait_cnt == WAIT_TC);

    // Set after clear so a fresh issue to the register being retired stays pending.
    always_comb begin
        busy_nxt = busy;
        if (mdu_ready && (mdu_addr != 5'd0))
            busy_nxt[mdu_addr] = 1'b0;
        if (issue_valid && (issue_addr != 5'd0))
            busy_nxt[issue_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grf_we   <= 1'b0;
            grf_a3   <= 5'd0;
            grf_wd   <= 32'd0;
            grf_pc   <= 32'd0;
            busy     <= 32'd0;
            wait_cnt <= '0;
        end else begin
            if (wb_eff) begin
                grf_we <= 1'b1;
                grf_a3 <= wb_addr;
                grf_wd <= wb_data;
                grf_pc <= wb_pc;
            end else if (mdu_valid && (mdu_addr != 5'd0)) begin
                grf_we <= 1'b1;
                grf_a3 <= mdu_addr;
                grf_wd <= mdu_data;
                grf_pc <= mdu_pc;
            end else begin
                grf_we <= 1'b0;
            end

            if (mdu_valid && !mdu_ready) begin
                if (wait_cnt != WAIT_TC)
                    wait_cnt <= wait_cnt + CNT_W'(1);
            end else begin
                wait_cnt <= '0;
            end

            busy <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_grf_wport_arbiter.sv
// Testbench for grf_wport_arbiter: directed vector table for the documented scenarios,
// then randomized traffic compared against a behavioural model of the arbitration rules.
module tb_grf_wport_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data, wb_pc;
    logic        mdu_valid, mdu_ready;
    logic [4:0]  mdu_addr;
    logic [31:0] mdu_data, mdu_pc;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic        stall_req;
    logic [31:0] busy;
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd, grf_pc;

    always #5 clk = ~clk;

    grf_wport_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_pc(wb_pc),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_addr(mdu_addr),
        .mdu_data(mdu_data), .mdu_pc(mdu_pc),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .stall_req(stall_req), .busy(busy),
        .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc)
    );

    typedef struct {
        logic        rst;
        logic        wbv;
        logic [4:0]  wba;
        logic [31:0] wbd, wbp;
        logic        mdv;
        logic [4:0]  mda;
        logic [31:0] mdd, mdp;
        logic        iv;
        logic [4:0]  ia;
        logic        e_rdy, e_we;
        logic [4:0]  e_a3;
        logic [31:0] e_wd, e_pc, e_busy;
        logic        e_stall;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model: write-port contents, per-register pending flags, blocked-cycle streak.
    logic        m_we;
    logic [4:0]  m_a3;
    logic [31:0] m_wd, m_pc;
    bit          pend[32];
    int          blocked;
    bit          last_rdy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic bit model_rdy();
        return mdu_valid && !(wb_valid && wb_addr != 5'd0);
    endfunction

    function automatic logic [31:0] model_busy();
        logic [31:0] b = '0;
        for (int i = 1; i < 32; i++) b[i] = pend[i];
        return b;
    endfunction

    task automatic model_step();
        bit wb_eff = wb_valid && (wb_addr != 5'd0);
        bit rdy    = model_rdy();
        last_rdy = rdy;
        if (reset) begin
            m_we = 0; m_a3 = 0; m_wd = 0; m_pc = 0; blocked = 0;
            for (int i = 0; i < 32; i++) pend[i] = 0;
        end else begin
            if (wb_eff) begin
                m_we = 1; m_a3 = wb_addr; m_wd = wb_data; m_pc = wb_pc;
            end else if (mdu_valid && mdu_addr != 5'd0) begin
                m_we = 1; m_a3 = mdu_addr; m_wd = mdu_data; m_pc = mdu_pc;
            end else begin
                m_we = 0;
            end
            if (mdu_valid && !rdy) blocked = (blocked < MAX_WAIT) ? blocked + 1 : MAX_WAIT;
            else                   blocked = 0;
            if (rdy && mdu_addr != 5'd0)         pend[mdu_addr] = 0;
            if (issue_valid && issue_addr != 5'd0) pend[issue_addr] = 1;
        end
    endtask

    function automatic vec_t mk(input logic rst, wbv, input logic [4:0] wba, input logic [31:0] wbd, wbp,
                                input logic mdv, input logic [4:0] mda, input logic [31:0] mdd, mdp,
                                input logic iv, input logic [4:0] ia,
                                input logic e_rdy, e_we, input logic [4:0] e_a3,
                                input logic [31:0] e_wd, e_pc, e_busy, input logic e_stall);
        vec_t v;
        v.rst = rst; v.wbv = wbv; v.wba = wba; v.wbd = wbd; v.wbp = wbp;
        v.mdv = mdv; v.mda = mda; v.mdd = mdd; v.mdp = mdp; v.iv = iv; v.ia = ia;
        v.e_rdy = e_rdy; v.e_we = e_we; v.e_a3 = e_a3; v.e_wd = e_wd; v.e_pc = e_pc;
        v.e_busy = e_busy; v.e_stall = e_stall;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        reset = v.rst; wb_valid = v.wbv; wb_addr = v.wba; wb_data = v.wbd; wb_pc = v.wbp;
        mdu_valid = v.mdv; mdu_addr = v.mda; mdu_data = v.mdd; mdu_pc = v.mdp;
        issue_valid = v.iv; issue_addr = v.ia;
    endtask

    // One clock: combinational ready checked before the edge, registered outputs #1 after it.
    task automatic cycle(input bit use_tbl, input vec_t v);
        #1;
        check("mdu_ready", mdu_ready, use_tbl ? v.e_rdy : model_rdy());
        model_step();
        @(posedge clk);
        #1;
        if (use_tbl) begin
            check("grf_we", grf_we, v.e_we);
            check("grf_a3", grf_a3, v.e_a3);
            check("grf_wd", grf_wd, v.e_wd);
            check("grf_pc", grf_pc, v.e_pc);
            check("busy", busy, v.e_busy);
            check("stall_req", stall_req, v.e_stall);
        end else begin
            check("grf_we", grf_we, m_we);
            if (m_we) begin
                check("grf_a3", grf_a3, m_a3);
                check("grf_wd", grf_wd, m_wd);
                check("grf_pc", grf_pc, m_pc);
            end
            check("busy", busy, model_busy());
            check("stall_req", stall_req, blocked == MAX_WAIT);
        end
    endtask

    initial begin
        vec_t v;
        // reset and pipeline-only write, then hold
        tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 0,0,  0,0,0,0,0,0,0));
        tbl.push_back(mk(0, 1,5,32'h1234,32'h3000, 0,0,0,0, 0,0,  0,1,5,32'h1234,32'h3000,0,0));
        tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0,  0,0,5,32'h1234,32'h3000,0,0));
        // $0 filtering on both sources
        tbl.push_back(mk(0, 1,0,32'hDEAD,32'h3004, 1,8,32'hAA,32'h4000, 0,0,  1,1,8,32'hAA,32'h4000,0,0));
        tbl.push_back(mk(0, 0,0,0,0, 1,0,32'hBB,32'h4004, 0,0,  1,0,8,32'hAA,32'h4000,0,0));
        // starvation: stall after four blocked cycles, pipeline keeps winning while it still drives
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 1,3,32'h33,32'h3008, 1,9,32'h99,32'h4008, 0,0,  0,1,3,32'h33,32'h3008,0,(i >= 3)));
        tbl.push_back(mk(0, 0,0,0,0, 1,9,32'h99,32'h4008, 0,0,  1,1,9,32'h99,32'h4008,0,0));
        // scoreboard set, clear, and set-wins-over-clear
        tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 1,10,  0,0,9,32'h99,32'h4008,32'h400,0));
        tbl.push_back(mk(0, 0,0,0,0, 1,10,32'h1010,32'h4010, 0,0,  1,1,10,32'h1010,32'h4010,0,0));
        tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 1,10,  0,0,10,32'h1010,32'h4010,32'h400,0));
        tbl.push_back(mk(0, 0,0,0,0, 1,10,32'h2020,32'h4014, 1,10,  1,1,10,32'h2020,32'h4014,32'h400,0));
        tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 1,9,  0,0,10,32'h2020,32'h4014,32'h600,0));
        // saturate, then reset mid-operation and watch the counter restart
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 1,3,32'h33,32'h3008, 1,9,32'h99,32'h4008, 0,0,  0,1,3,32'h33,32'h3008,32'h600,(i == 3)));
        tbl.push_back(mk(1, 1,3,32'h33,32'h3008, 1,9,32'h99,32'h4008, 1,11,  0,0,0,0,0,0,0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 1,3,32'h33,32'h3008, 1,9,32'h99,32'h4008, 0,0,  0,1,3,32'h33,32'h3008,0,(i == 3)));
        tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0,  0,0,3,32'h33,32'h3008,0,0));
        tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 1,0,  0,0,3,32'h33,32'h3008,0,0));

        foreach (tbl[i]) begin
            apply(tbl[i]);
            cycle(1'b1, tbl[i]);
        end

        // randomized traffic against the model, starting from a reset
        v = mk(1, 0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0,0,0,0);
        apply(v);
        cycle(1'b0, v);
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 149) == 0);
            if (blocked == MAX_WAIT) wb_valid = ($urandom_range(0, 5) == 0);
            else                     wb_valid = $urandom_range(0, 1) != 0;
            wb_addr = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            wb_data = $urandom;
            wb_pc   = $urandom;
            // MDU holds its result stable until accepted
            if (!mdu_valid || last_rdy) begin
                mdu_valid = $urandom_range(0, 2) != 0;
                mdu_addr  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
                mdu_data  = $urandom;
                mdu_pc    = $urandom;
            end
            issue_valid = $urandom_range(0, 2) == 0;
            issue_addr  = 5'($urandom_range(0, 7));
            cycle(1'b0, v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
